// File: rtl/pwm_pkg.sv
// Shared widths, types and constants for the multi-channel PWM generator.
package pwm_pkg;

  localparam int DUTY_W_MAX = 16;

  typedef logic [DUTY_W_MAX-1:0] duty_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int duty_width(input int period);
    return $clog2(period + 1);
  endfunction

  // Sized to hold PERIOD itself, which the up-down carrier reaches.
  function automatic int cnt_width(input int period);
    return $clog2(period + 1);
  endfunction

  function automatic duty_t reset_duty(input int period);
    return duty_t'(period / 2);
  endfunction

endpackage

// File: rtl/pwm_generator_mc_if.sv
// Button inputs and PWM/duty outputs of the multi-channel PWM generator.
interface pwm_generator_mc_if #(
  parameter int CHANNELS = 4,
  parameter int DUTY_W   = 4
);
  logic [CHANNELS-1:0]             increase_duty;
  logic [CHANNELS-1:0]             decrease_duty;
  logic [CHANNELS-1:0]             PWM_OUT;
  logic [CHANNELS-1:0][DUTY_W-1:0] duty_o;
  logic                            period_start;

  modport master (
    output increase_duty, decrease_duty,
    input  PWM_OUT, duty_o, period_start
  );

  modport slave (
    input  increase_duty, decrease_duty,
    output PWM_OUT, duty_o, period_start
  );
endinterface

// File: rtl/pwm_debounce.sv
// Two-flop synchroniser, stable-high debounce counter and one-cycle press pulse
// on the rising edge of the debounced level.
module pwm_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic press_o
);

  localparam int DC_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [DC_W-1:0] cnt_q, cnt_d;
  logic            lvl_q, lvl_d;
  logic            lvl_prev_q;

  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (!sync_q[1]) begin
      cnt_d = '0;
      lvl_d = 1'b0;
    end else if (cnt_q != DC_W'(DEB_CYCLES)) begin
      cnt_d = cnt_q + DC_W'(1);
      lvl_d = (cnt_d == DC_W'(DEB_CYCLES));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], din_i};
      cnt_q      <= cnt_d;
      lvl_q      <= lvl_d;
      lvl_prev_q <= lvl_q;
    end
  end

  // Holding the button keeps lvl_q high, so only one pulse per press.
  assign press_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/pwm_generator_mc.sv
// Multi-channel PWM generator: shared carrier, per-channel debounced duty
// controls, duty applied only at carrier wrap. Define PWM_CENTER_ALIGNED_EN
// for an up-down (center-aligned) carrier.
module pwm_generator_mc
  import pwm_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int PERIOD     = 10,
  parameter int STEP       = 1,
  parameter int DEB_CYCLES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pwm_generator_mc_if.slave bus
);

  localparam int DUTY_W = duty_width(PERIOD);
  localparam int CNT_W  = cnt_width(PERIOD);
  localparam logic [DUTY_W-1:0] RST_DUTY = DUTY_W'(reset_duty(PERIOD));

  logic [CHANNELS-1:0]             inc_press, dec_press;
  logic [CHANNELS-1:0][DUTY_W-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0][DUTY_W-1:0] active_q, active_d;
  logic [CHANNELS-1:0]             pwm_q, pwm_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic                            ps_q;
  logic                            wrap;
`ifdef PWM_CENTER_ALIGNED_EN
  dir_e                            dir_q, dir_d;
`endif

  function automatic logic [DUTY_W-1:0] sat_up(input logic [DUTY_W-1:0] d);
    logic [DUTY_W:0] s;
    s = {1'b0, d} + (DUTY_W+1)'(STEP);
    return (s > (DUTY_W+1)'(PERIOD)) ? DUTY_W'(PERIOD) : s[DUTY_W-1:0];
  endfunction

  function automatic logic [DUTY_W-1:0] sat_dn(input logic [DUTY_W-1:0] d);
    return (d < DUTY_W'(STEP)) ? '0 : d - DUTY_W'(STEP);
  endfunction

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_i   (bus.increase_duty[i]),
      .press_o (inc_press[i])
    );
    pwm_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_i   (bus.decrease_duty[i]),
      .press_o (dec_press[i])
    );
  end

  // Carrier next state.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
    dir_d = dir_q;
    if (dir_q == DIR_UP) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(PERIOD - 1)) dir_d = DIR_DOWN;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        dir_d = DIR_UP;
        wrap  = 1'b1;
      end
    end
`else
    if (cnt_q == CNT_W'(PERIOD - 1)) begin
      cnt_d = '0;
      wrap  = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
  end

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (inc_press[i] && !dec_press[i])      pend_d[i] = sat_up(pend_q[i]);
      else if (dec_press[i] && !inc_press[i]) pend_d[i] = sat_dn(pend_q[i]);
    end
  end

  // Counting phase: cnt 0..PERIOD-1 while rising, PERIOD..1 while falling;
  // comparing with <= on the way down gives exactly 2*duty high cycles.
  always_comb begin
    active_d = wrap ? pend_q : active_q;
    pwm_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_CENTER_ALIGNED_EN
      if (dir_q == DIR_UP) pwm_d[i] = (cnt_q <  active_q[i]) || (active_q[i] == DUTY_W'(PERIOD));
      else                 pwm_d[i] = (cnt_q <= active_q[i]) || (active_q[i] == DUTY_W'(PERIOD));
`else
      pwm_d[i] = (cnt_q < active_q[i]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pwm_q    <= '0;
      ps_q     <= 1'b0;
      pend_q   <= {CHANNELS{RST_DUTY}};
      active_q <= {CHANNELS{RST_DUTY}};
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= DIR_UP;
`endif
    end else begin
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
      ps_q     <= wrap;
      pend_q   <= pend_d;
      active_q <= active_d;
`ifdef PWM_CENTER_ALIGNED_EN
      dir_q    <= dir_d;
`endif
    end
  end

  assign bus.PWM_OUT      = pwm_q;
  assign bus.duty_o       = active_q;
  assign bus.period_start = ps_q;

endmodule

// File: tb/tb_pwm_generator_mc.sv
// Directed testbench for pwm_generator_mc (edge-aligned build, PERIOD=10).
module tb_pwm_generator_mc;

  localparam int CH = 4;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pwm_generator_mc_if #(.CHANNELS(CH), .DUTY_W(DW)) bus ();

  pwm_generator_mc #(
    .CHANNELS(CH), .PERIOD(10), .STEP(1), .DEB_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.period_start !== 1'b1 && n < 25);
    if (bus.period_start !== 1'b1) chk({tag, "_ps_timeout"}, 0, 1);
  endtask

  // Samples following a period_start sample cover carrier values 0..9.
  task automatic count_high(input int ch, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.PWM_OUT[ch]) n++;
    end
  endtask

  task automatic press(input logic [CH-1:0] inc, input logic [CH-1:0] dec);
    bus.increase_duty = inc;
    bus.decrease_duty = dec;
    repeat (10) @(negedge clk);
    bus.increase_duty = '0;
    bus.decrease_duty = '0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.increase_duty = '0;
    bus.decrease_duty = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm", int'(bus.PWM_OUT), 0);
    chk("rst_ps", int'(bus.period_start), 0);
    for (int i = 0; i < CH; i++) chk($sformatf("rst_duty%0d", i), int'(bus.duty_o[i]), 5);

    // Release: 5 high / 5 low, first period_start ten edges after release
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk($sformatf("pat_k%0d", k), int'(bus.PWM_OUT), (((k - 1) % 10) < 5) ? 4'hF : 4'h0);
      chk($sformatf("ps_k%0d", k), int'(bus.period_start), (k % 10 == 0) ? 1 : 0);
    end

    // Saturation high on ch0
    repeat (6) press(4'b0001, 4'b0000);
    wait_ps("sat_hi");
    chk("sat_hi_duty0", int'(bus.duty_o[0]), 10);
    for (int i = 1; i < CH; i++) chk($sformatf("sat_hi_duty%0d", i), int'(bus.duty_o[i]), 5);
    count_high(0, n);
    chk("sat_hi_high0", n, 10);

    // Saturation low on ch0
    repeat (11) press(4'b0000, 4'b0001);
    wait_ps("sat_lo");
    chk("sat_lo_duty0", int'(bus.duty_o[0]), 0);
    count_high(0, n);
    chk("sat_lo_high0", n, 0);
    chk("sat_lo_duty1", int'(bus.duty_o[1]), 5);

    // Debounce: 3-cycle glitch rejected, long hold gives one step
    bus.increase_duty = 4'b0010;
    repeat (3) @(negedge clk);
    bus.increase_duty = '0;
    repeat (20) @(negedge clk);
    wait_ps("glitch");
    chk("glitch_duty1", int'(bus.duty_o[1]), 5);
    bus.increase_duty = 4'b0010;
    repeat (20) @(negedge clk);
    bus.increase_duty = '0;
    repeat (10) @(negedge clk);
    wait_ps("hold");
    chk("hold_duty1", int'(bus.duty_o[1]), 6);
    count_high(1, n);
    chk("hold_high1", n, 6);

    // Simultaneous inc and dec on ch2
    press(4'b0100, 4'b0100);
    wait_ps("simul");
    chk("simul_duty2", int'(bus.duty_o[2]), 5);
    count_high(2, n);
    chk("simul_high2", n, 5);

    // Mid-period press on ch3 keeps current pulse width
    wait_ps("glfree");
    bus.increase_duty = 4'b1000;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.PWM_OUT[3]) n++;
      if (k == 8) chk("glfree_duty_before", int'(bus.duty_o[3]), 5);
    end
    chk("glfree_old_high", n, 5);
    chk("glfree_ps", int'(bus.period_start), 1);
    chk("glfree_duty_after", int'(bus.duty_o[3]), 6);
    bus.increase_duty = '0;
    count_high(3, n);
    chk("glfree_new_high", n, 6);

    // Bring ch0 to 8, then reset mid-period
    repeat (8) press(4'b0001, 4'b0000);
    wait_ps("to8");
    chk("to8_duty0", int'(bus.duty_o[0]), 8);
    count_high(0, n);
    chk("to8_high0", n, 8);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_pwm", int'(bus.PWM_OUT), 0);
    chk("mrst_duty0", int'(bus.duty_o[0]), 5);
    chk("mrst_duty3", int'(bus.duty_o[3]), 5);
    chk("mrst_ps", int'(bus.period_start), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.period_start !== 1'b1 && n < 25);
    chk("mrst_first_ps", n, 10);
    count_high(0, n);
    chk("mrst_high0", n, 5);
    chk("mrst_duty1", int'(bus.duty_o[1]), 5);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
